// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Desc     : RV32I decode stage: 32-entry register file with write-through
//            bypass, immediate/control decode, load-use interlock, ID/EX reg.
// Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int ARCH_LEN = 32,
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INST_LEN-1:0] inst_in,
    input  logic [ARCH_LEN-1:0] pc_in,
    input  logic                flush_in,
    input  logic                stall_in,
    input  logic                ex_is_load,
    input  logic [4:0]          ex_rd,
    input  logic                wb_en,
    input  logic [4:0]          wb_rd,
    input  logic [ARCH_LEN-1:0] wb_data,
    output logic                stall_fet_out,
    output logic                valid_out,
    output logic [ARCH_LEN-1:0] pc_out,
    output logic [ARCH_LEN-1:0] rs1_data_out,
    output logic [ARCH_LEN-1:0] rs2_data_out,
    output logic [ARCH_LEN-1:0] imm_out,
    output logic [4:0]          rs1_out,
    output logic [4:0]          rs2_out,
    output logic [4:0]          rd_out,
    output logic [2:0]          funct3_out,
    output logic                funct7b5_out,
    output logic                reg_write_out,
    output logic                mem_read_out,
    output logic                mem_write_out,
    output logic                branch_out,
    output logic                jump_out,
    output logic                alu_src_imm_out,
    output logic                pc_src_out,
    output logic                illegal_out
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;

    typedef struct packed {
        logic                valid;
        logic                illegal;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic                alu_src_imm;
        logic                pc_src;
        logic [ARCH_LEN-1:0] pc;
        logic [ARCH_LEN-1:0] rs1_data;
        logic [ARCH_LEN-1:0] rs2_data;
        logic [ARCH_LEN-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic                funct7b5;
    } idex_t;

    logic [ARCH_LEN-1:0] r_regs [0:31];
    idex_t               r_idex;

    logic [31:0]         w_inst;
    logic [6:0]          w_opcode;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic [31:0]         w_imm_i;
    logic [31:0]         w_imm_s;
    logic [31:0]         w_imm_b;
    logic [31:0]         w_imm_u;
    logic [31:0]         w_imm_j;
    logic [31:0]         w_imm32;
    logic [ARCH_LEN-1:0] w_rs1_data;
    logic [ARCH_LEN-1:0] w_rs2_data;
    logic                w_use_rs1;
    logic                w_use_rs2;
    logic                w_load_use;
    idex_t               w_dec;

    assign w_inst   = inst_in[31:0];
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'h000};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // Register file: x0 is never written, so it stays at its reset value of 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        w_rs1_data = r_regs[w_rs1];
        if (w_rs1 == 5'd0) begin
            w_rs1_data = '0;
        end else if (wb_en && (wb_rd == w_rs1)) begin
            w_rs1_data = wb_data;
        end
    end

    always_comb begin
        w_rs2_data = r_regs[w_rs2];
        if (w_rs2 == 5'd0) begin
            w_rs2_data = '0;
        end else if (wb_en && (wb_rd == w_rs2)) begin
            w_rs2_data = wb_data;
        end
    end

    // All-zero instruction word is the fetch stage's bubble, not an illegal opcode
    always_comb begin
        w_dec     = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_imm32   = 32'h0;
        if (inst_in != '0) begin
            w_dec.valid = 1'b1;
            case (w_opcode)
                c_OP_LUI: begin
                    w_dec.reg_write   = 1'b1;
                    w_dec.alu_src_imm = 1'b1;
                    w_imm32           = w_imm_u;
                end
                c_OP_AUIPC: begin
                    w_dec.reg_write   = 1'b1;
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.pc_src      = 1'b1;
                    w_imm32           = w_imm_u;
                end
                c_OP_JAL: begin
                    w_dec.reg_write   = 1'b1;
                    w_dec.jump        = 1'b1;
                    w_dec.alu_src_imm = 1'b1;
                    w_dec.pc_src      = 1'b1;
                    w_imm32           = w_imm_j;
                end
                c_OP_JALR: begin
                    w_dec.reg_write   = 1'b1;
                    w_dec.jump        = 1'b1;
                    w_dec.alu_src_imm = 1'b1;
                    w_use_rs1         = 1'b1;
                    w_imm32           = w_imm_i;
                end
                c_OP_BRANCH: begin
                    w_dec.branch = 1'b1;
                    w_use_rs1    = 1'b1;
                    w_use_rs2    = 1'b1;
                    w_imm32      = w_imm_b;
                end
                c_OP_LOAD: begin
                    w_dec.reg_write   = 1'b1;
                    w_dec.mem_read    = 1'b1;
                    w_dec.alu_src_imm = 1'b1;
                    w_use_rs1         = 1'b1;
                    w_imm32           = w_imm_i;
                end
                c_OP_STORE: begin
                    w_dec.mem_write   = 1'b1;
                    w_dec.alu_src_imm = 1'b1;
                    w_use_rs1         = 1'b1;
                    w_use_rs2         = 1'b1;
                    w_imm32           = w_imm_s;
                end
                c_OP_IMM: begin
                    w_dec.reg_write   = 1'b1;
                    w_dec.alu_src_imm = 1'b1;
                    w_use_rs1         = 1'b1;
                    w_imm32           = w_imm_i;
                end
                c_OP_OP: begin
                    w_dec.reg_write = 1'b1;
                    w_use_rs1       = 1'b1;
                    w_use_rs2       = 1'b1;
                end
                default: begin
                    w_dec.illegal = 1'b1;
                end
            endcase
            if (w_rd == 5'd0) begin
                w_dec.reg_write = 1'b0;
            end
        end
        w_dec.pc       = pc_in;
        w_dec.rs1_data = w_rs1_data;
        w_dec.rs2_data = w_rs2_data;
        w_dec.imm      = ARCH_LEN'($signed(w_imm32));
        w_dec.rs1      = w_rs1;
        w_dec.rs2      = w_rs2;
        w_dec.rd       = w_rd;
        w_dec.funct3   = w_inst[14:12];
        w_dec.funct7b5 = w_inst[30];
    end

    assign w_load_use = ex_is_load && (ex_rd != 5'd0) &&
                        ((w_use_rs1 && (ex_rd == w_rs1)) || (w_use_rs2 && (ex_rd == w_rs2)));

    assign stall_fet_out = !rst && !flush_in && (stall_in || w_load_use);

    // Priority: reset, flush, downstream hold, load-use bubble, capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex <= '0;
        end else if (flush_in) begin
            r_idex <= '0;
        end else if (stall_in) begin
            r_idex <= r_idex;
        end else if (w_load_use) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_dec;
        end
    end

    assign valid_out       = r_idex.valid;
    assign illegal_out     = r_idex.illegal;
    assign reg_write_out   = r_idex.reg_write;
    assign mem_read_out    = r_idex.mem_read;
    assign mem_write_out   = r_idex.mem_write;
    assign branch_out      = r_idex.branch;
    assign jump_out        = r_idex.jump;
    assign alu_src_imm_out = r_idex.alu_src_imm;
    assign pc_src_out      = r_idex.pc_src;
    assign pc_out          = r_idex.pc;
    assign rs1_data_out    = r_idex.rs1_data;
    assign rs2_data_out    = r_idex.rs2_data;
    assign imm_out         = r_idex.imm;
    assign rs1_out         = r_idex.rs1;
    assign rs2_out         = r_idex.rs2;
    assign rd_out          = r_idex.rd;
    assign funct3_out      = r_idex.funct3;
    assign funct7b5_out    = r_idex.funct7b5;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Desc     : Directed self-checking bench for decode_stage with a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic        flush_in;
    logic        stall_in;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_fet_out;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic [31:0] imm_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3_out;
    logic        funct7b5_out;
    logic        reg_write_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        branch_out;
    logic        jump_out;
    logic        alu_src_imm_out;
    logic        pc_src_out;
    logic        illegal_out;

    always #5 clk = ~clk;

    decode_stage #(.ARCH_LEN(32), .INST_LEN(32)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .pc_in(pc_in),
        .flush_in(flush_in), .stall_in(stall_in),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_fet_out(stall_fet_out), .valid_out(valid_out), .pc_out(pc_out),
        .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .funct3_out(funct3_out), .funct7b5_out(funct7b5_out),
        .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .branch_out(branch_out), .jump_out(jump_out),
        .alu_src_imm_out(alu_src_imm_out), .pc_src_out(pc_src_out),
        .illegal_out(illegal_out)
    );

    // full=0 marks a bubble whose data fields carry no meaning
    typedef struct packed {
        bit        full;
        bit        valid;
        bit        illegal;
        bit        rw;
        bit        mr;
        bit        mw;
        bit        br;
        bit        jp;
        bit        asi;
        bit        pcs;
        bit [31:0] pc;
        bit [31:0] d1;
        bit [31:0] d2;
        bit [31:0] imm;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [4:0]  rd;
        bit [2:0]  f3;
        bit        f7;
    } exp_t;

    exp_t      exp_q;
    bit [31:0] m_rf [32];
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit [31:0] m_read(input bit [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_en && (wb_rd == r)) return wb_data;
        return m_rf[r];
    endfunction

    function automatic exp_t m_decode(input bit [31:0] inst, output bit u1, output bit u2);
        exp_t      e;
        bit [31:0] sx;
        e  = '0;
        u1 = 1'b0;
        u2 = 1'b0;
        if (inst == 32'h0) return e;
        sx      = inst[31] ? 32'hFFFF_FFFF : 32'h0;
        e.full  = 1'b1;
        e.valid = 1'b1;
        e.pc    = pc_in;
        e.rs1   = inst[19:15];
        e.rs2   = inst[24:20];
        e.rd    = inst[11:7];
        e.f3    = inst[14:12];
        e.f7    = inst[30];
        e.d1    = m_read(e.rs1);
        e.d2    = m_read(e.rs2);
        case (inst[6:0])
            7'h37: begin e.rw = 1; e.asi = 1; e.imm = inst & 32'hFFFF_F000; end
            7'h17: begin e.rw = 1; e.asi = 1; e.pcs = 1; e.imm = inst & 32'hFFFF_F000; end
            7'h6F: begin
                e.rw = 1; e.jp = 1; e.asi = 1; e.pcs = 1;
                e.imm = (sx << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            end
            7'h67: begin e.rw = 1; e.jp = 1; e.asi = 1; u1 = 1; e.imm = (sx << 12) | 32'(inst[31:20]); end
            7'h63: begin
                e.br = 1; u1 = 1; u2 = 1;
                e.imm = (sx << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            end
            7'h03: begin e.rw = 1; e.mr = 1; e.asi = 1; u1 = 1; e.imm = (sx << 12) | 32'(inst[31:20]); end
            7'h23: begin
                e.mw = 1; e.asi = 1; u1 = 1; u2 = 1;
                e.imm = (sx << 12) | (32'(inst[31:25]) << 5) | 32'(inst[11:7]);
            end
            7'h13: begin e.rw = 1; e.asi = 1; u1 = 1; e.imm = (sx << 12) | 32'(inst[31:20]); end
            7'h33: begin e.rw = 1; u1 = 1; u2 = 1; end
            default: e.illegal = 1;
        endcase
        if (e.rd == 5'd0) e.rw = 0;
        return e;
    endfunction

    function automatic bit m_hazard(input exp_t e, input bit u1, input bit u2);
        return ex_is_load && (ex_rd != 5'd0) &&
               ((u1 && (ex_rd == e.rs1)) || (u2 && (ex_rd == e.rs2)));
    endfunction

    // Model advances on each rising edge, then the registered outputs are compared
    always @(posedge clk) begin : p_model
        bit   u1, u2;
        exp_t nxt;
        if (rst) begin
            exp_q      = '0;
            exp_q.full = 1'b1;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        end else begin
            nxt = m_decode(inst_in, u1, u2);
            if (flush_in) exp_q = '0;
            else if (!stall_in) exp_q = m_hazard(nxt, u1, u2) ? '0 : nxt;
            if (wb_en && (wb_rd != 5'd0)) m_rf[wb_rd] = wb_data;
        end
        #1;
        chk("valid",   32'(valid_out),       32'(exp_q.valid));
        chk("illegal", 32'(illegal_out),     32'(exp_q.illegal));
        chk("rw",      32'(reg_write_out),   32'(exp_q.rw));
        chk("mr",      32'(mem_read_out),    32'(exp_q.mr));
        chk("mw",      32'(mem_write_out),   32'(exp_q.mw));
        chk("br",      32'(branch_out),      32'(exp_q.br));
        chk("jp",      32'(jump_out),        32'(exp_q.jp));
        chk("asi",     32'(alu_src_imm_out), 32'(exp_q.asi));
        chk("pcs",     32'(pc_src_out),      32'(exp_q.pcs));
        if (exp_q.full) begin
            chk("pc",  pc_out,           exp_q.pc);
            chk("d1",  rs1_data_out,     exp_q.d1);
            chk("d2",  rs2_data_out,     exp_q.d2);
            chk("imm", imm_out,          exp_q.imm);
            chk("rs1", 32'(rs1_out),     32'(exp_q.rs1));
            chk("rs2", 32'(rs2_out),     32'(exp_q.rs2));
            chk("rd",  32'(rd_out),      32'(exp_q.rd));
            chk("f3",  32'(funct3_out),  32'(exp_q.f3));
            chk("f7",  32'(funct7b5_out), 32'(exp_q.f7));
        end
    end

    always @(negedge clk) begin : p_stall_chk
        bit   u1, u2;
        exp_t tmp;
        bit   e_st;
        tmp  = m_decode(inst_in, u1, u2);
        e_st = !rst && !flush_in && (stall_in || m_hazard(tmp, u1, u2));
        chk("stall_fet", 32'(stall_fet_out), 32'(e_st));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    bit [31:0] v_inst [10] = '{32'h1234_50B7, 32'h0000_1197, 32'h0080_00EF, 32'h0000_8067,
                               32'h0041_2283, 32'h0051_2423, 32'h4020_81B3, 32'h0000_0013,
                               32'hFFF0_8093, 32'h0000_0080};
    bit [31:0] v_imm  [10] = '{32'h1234_5000, 32'h0000_1000, 32'h0000_0008, 32'h0000_0000,
                               32'h0000_0004, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000,
                               32'hFFFF_FFFF, 32'h0000_0000};

    initial begin
        rst = 1; inst_in = 32'h0010_8093; pc_in = 32'h40; flush_in = 0; stall_in = 1;
        ex_is_load = 0; ex_rd = 0; wb_en = 1; wb_rd = 5'd3; wb_data = 32'h99;
        #1;
        chk("lit_rst_stall_fet", 32'(stall_fet_out), 32'h0);
        tick(); tick();
        chk("lit_rst_valid", 32'(valid_out), 32'h0);
        chk("lit_rst_pc",    pc_out,         32'h0);
        chk("lit_rst_imm",   imm_out,        32'h0);
        chk("lit_rst_rw",    32'(reg_write_out), 32'h0);

        // addi x1,x1,1 straight after reset
        rst = 0; stall_in = 0; wb_en = 0; pc_in = 32'h0;
        tick();
        chk("lit_addi_valid", 32'(valid_out), 32'h1);
        chk("lit_addi_rd",    32'(rd_out),    32'h1);
        chk("lit_addi_rs1",   32'(rs1_out),   32'h1);
        chk("lit_addi_imm",   imm_out,        32'h1);
        chk("lit_addi_rw",    32'(reg_write_out),   32'h1);
        chk("lit_addi_asi",   32'(alu_src_imm_out), 32'h1);
        chk("lit_addi_d1",    rs1_data_out,   32'h0);

        wb_en = 1; wb_rd = 5'd1; wb_data = 32'h5; pc_in = 32'h4;
        tick();
        chk("lit_bypass_d1", rs1_data_out, 32'h5);

        wb_rd = 5'd2; wb_data = 32'h77; inst_in = 32'h0020_81B3; pc_in = 32'h8;
        tick();
        chk("lit_add_d1", rs1_data_out, 32'h5);
        chk("lit_add_d2", rs2_data_out, 32'h77);
        wb_en = 0;

        // load-use on rs1
        ex_is_load = 1; ex_rd = 5'd1; inst_in = 32'h0010_8093; pc_in = 32'hC;
        #1; chk("lit_lu_stall_fet", 32'(stall_fet_out), 32'h1);
        tick();
        chk("lit_lu_bubble", 32'(valid_out), 32'h0);
        ex_is_load = 0;
        tick();
        chk("lit_lu_resume_valid", 32'(valid_out), 32'h1);
        chk("lit_lu_resume_rd",    32'(rd_out),    32'h1);
        chk("lit_lu_resume_pc",    pc_out,         32'hC);

        // load in EX writing a register the instruction does not read
        ex_is_load = 1; ex_rd = 5'd2;
        #1; chk("lit_nolu_stall_fet", 32'(stall_fet_out), 32'h0);
        tick();
        chk("lit_nolu_valid", 32'(valid_out), 32'h1);
        inst_in = 32'h0020_81B3; pc_in = 32'h10;
        #1; chk("lit_lu_rs2_stall_fet", 32'(stall_fet_out), 32'h1);
        tick();
        ex_rd = 5'd0; inst_in = 32'h0000_0093;
        #1; chk("lit_lu_x0_stall_fet", 32'(stall_fet_out), 32'h0);
        tick();
        ex_is_load = 0;

        // downstream hold for three cycles, writes still land
        inst_in = 32'h0070_0113; pc_in = 32'h10;
        tick();
        stall_in = 1; inst_in = 32'h1234_50B7; pc_in = 32'h14;
        wb_en = 1; wb_rd = 5'd4; wb_data = 32'h44;
        for (int i = 0; i < 3; i++) begin
            #1; chk("lit_hold_stall_fet", 32'(stall_fet_out), 32'h1);
            tick();
            chk("lit_hold_rd",  32'(rd_out), 32'h2);
            chk("lit_hold_imm", imm_out,     32'h7);
            chk("lit_hold_pc",  pc_out,      32'h10);
        end
        wb_en = 0; flush_in = 1;
        #1; chk("lit_flush_stall_fet", 32'(stall_fet_out), 32'h0);
        tick();
        chk("lit_flush_valid", 32'(valid_out), 32'h0);
        flush_in = 0; stall_in = 0;

        inst_in = 32'h0002_02B3; pc_in = 32'h1C;
        tick();
        chk("lit_stall_wb_d1", rs1_data_out, 32'h44);

        inst_in = 32'hFE00_0EE3; pc_in = 32'h20;
        tick();
        chk("lit_beq_br",  32'(branch_out), 32'h1);
        chk("lit_beq_imm", imm_out,         32'hFFFF_FFFC);

        inst_in = 32'hFFFF_FFFF; pc_in = 32'h24;
        tick();
        chk("lit_ill_illegal", 32'(illegal_out),   32'h1);
        chk("lit_ill_valid",   32'(valid_out),     32'h1);
        chk("lit_ill_rw",      32'(reg_write_out), 32'h0);

        for (int i = 0; i < 10; i++) begin
            inst_in = v_inst[i]; pc_in = 32'h100 + 32'(i) * 4;
            tick();
            chk("lit_vec_imm", imm_out, v_imm[i]);
        end

        // write to x0 is discarded, even in the bypass path
        wb_en = 1; wb_rd = 5'd0; wb_data = 32'hDEAD; inst_in = 32'h0000_0093; pc_in = 32'h200;
        tick();
        chk("lit_x0_bypass", rs1_data_out, 32'h0);
        wb_en = 0;
        tick();
        chk("lit_x0_read", rs1_data_out, 32'h0);

        // reset arriving during a hold
        inst_in = 32'h0070_0113; pc_in = 32'h300;
        tick();
        stall_in = 1;
        tick();
        rst = 1;
        #1; chk("lit_rst_hold_stall_fet", 32'(stall_fet_out), 32'h0);
        tick();
        chk("lit_rst_hold_valid", 32'(valid_out), 32'h0);
        chk("lit_rst_hold_pc",    pc_out,         32'h0);
        chk("lit_rst_hold_imm",   imm_out,        32'h0);
        chk("lit_rst_hold_rd",    32'(rd_out),    32'h0);
        rst = 0; stall_in = 0; inst_in = 32'h0010_8093; pc_in = 32'h0;
        tick();
        chk("lit_rf_cleared", rs1_data_out, 32'h0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
